// File: rtl/multicycle_sequencer.sv
// Multicycle LEGv8 control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a req/ack memory,
// with a retired-instruction counter, a halt state and a sticky memory-timeout fault.
module multicycle_sequencer #(
  parameter int CNTWIDTH = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ack,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                branch,
  input  logic                setflags,
  input  logic                regwrite,
  input  logic                halt,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_en,
  output logic                mdr_en,
  output logic                pc_en,
  output logic                pc_src,
  output logic                reg_we,
  output logic                flags_we,
  output logic                retire,
  output logic [CNTWIDTH-1:0] instret,
  output logic [2:0]          state,
  output logic                fault
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam int WAITW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAITW-1:0] TO_W = WAITW'(TIMEOUT);

  state_t               r_state;
  state_t               w_next;
  logic [WAITW-1:0]     r_wait;
  logic [CNTWIDTH-1:0]  r_instret;
  logic                 r_fault;
  logic                 w_timeout;
  logic                 w_mem_req, w_mem_we, w_addr_sel, w_ir_en, w_mdr_en;
  logic                 w_pc_en, w_pc_src, w_reg_we, w_flags_we, w_retire;

  always_comb begin
    w_next     = r_state;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_addr_sel = 1'b0;
    w_ir_en    = 1'b0;
    w_mdr_en   = 1'b0;
    w_pc_en    = 1'b0;
    w_pc_src   = 1'b0;
    w_reg_we   = 1'b0;
    w_flags_we = 1'b0;
    w_retire   = 1'b0;
    // An ack in the final wait cycle beats the timeout.
    w_timeout  = (TIMEOUT != 0) && (r_wait == TO_W) && !mem_ack;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ack) begin
          w_ir_en = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: w_next = S_EXECUTE;
      S_EXECUTE: begin
        if (is_load || is_store) begin
          w_next = S_MEMORY;
        end else begin
          w_flags_we = setflags;
          w_reg_we   = regwrite;
          w_pc_en    = 1'b1;
          w_pc_src   = branch;
          w_retire   = 1'b1;
          w_next     = halt ? S_HALTED : S_FETCH;
        end
      end
      S_MEMORY: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = is_store && !is_load;
        if (mem_ack) begin
          if (is_load) begin
            w_mdr_en = 1'b1;
            w_next   = S_WRITEBACK;
          end else begin
            w_pc_en  = 1'b1;
            w_retire = 1'b1;
            w_next   = halt ? S_HALTED : S_FETCH;
          end
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        w_reg_we = 1'b1;
        w_pc_en  = 1'b1;
        w_retire = 1'b1;
        w_next   = halt ? S_HALTED : S_FETCH;
      end
      S_HALTED: w_next = S_HALTED;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FAULT) r_fault <= 1'b1;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH || r_state == S_MEMORY) && !mem_ack && r_wait != TO_W) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  // Gating with rst makes an in-flight request vanish the moment reset asserts.
  assign mem_req  = w_mem_req  & rst;
  assign mem_we   = w_mem_we   & rst;
  assign addr_sel = w_addr_sel & rst;
  assign ir_en    = w_ir_en    & rst;
  assign mdr_en   = w_mdr_en   & rst;
  assign pc_en    = w_pc_en    & rst;
  assign pc_src   = w_pc_src   & rst;
  assign reg_we   = w_reg_we   & rst;
  assign flags_we = w_flags_we & rst;
  assign retire   = w_retire   & rst;
  assign instret  = r_instret;
  assign state    = r_state;
  assign fault    = r_fault;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer (CNTWIDTH=4, TIMEOUT=4): per-instruction cycle traces built
// from the phase rules, with random memory latencies and random ignored acks.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst, mem_ack, is_load, is_store, branch, setflags, regwrite, halt;
  logic       mem_req, mem_we, addr_sel, ir_en, mdr_en, pc_en, pc_src, reg_we, flags_we, retire;
  logic [3:0] instret;
  logic [2:0] state;
  logic       fault;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_instret;

  multicycle_sequencer #(.CNTWIDTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_ack(mem_ack), .is_load(is_load), .is_store(is_store),
    .branch(branch), .setflags(setflags), .regwrite(regwrite), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en), .mdr_en(mdr_en),
    .pc_en(pc_en), .pc_src(pc_src), .reg_we(reg_we), .flags_we(flags_we), .retire(retire),
    .instret(instret), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] pk(input logic [2:0] st, input logic req, we, asel, ir, mdr,
                                     input logic pce, pcs, rwe, fwe, ret);
    return {st, req, we, asel, ir, mdr, pce, pcs, rwe, fwe, ret};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {state, mem_req, mem_we, addr_sel, ir_en, mdr_en, pc_en, pc_src, reg_we, flags_we, retire};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    {mem_ack, is_load, is_store, branch, setflags, regwrite, halt} = '0;
    model_instret = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drives one instruction with the given memory latencies and checks every cycle of it.
  task automatic run_instr(input string tag, input int kind, input int fdly, input int mdly,
                           input logic sf, input logic rw, input logic br, input logic hl,
                           input logic both);
    logic        aq[$];
    logic [12:0] eq[$];
    logic [12:0] obs;
    is_load  = (kind == 1);
    is_store = (kind == 2) || (kind == 1 && both);
    branch   = br;
    setflags = sf;
    regwrite = rw;
    halt     = hl;
    for (int i = 0; i < fdly; i++) begin
      aq.push_back(1'b0); eq.push_back(pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    aq.push_back(1'b1); eq.push_back(pk(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    aq.push_back(1'($urandom_range(0, 1))); eq.push_back(pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (kind == 0) begin
      aq.push_back(1'($urandom_range(0, 1))); eq.push_back(pk(3'd2, 0, 0, 0, 0, 0, 1, br, rw, sf, 1));
    end else begin
      aq.push_back(1'($urandom_range(0, 1))); eq.push_back(pk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < mdly; i++) begin
        aq.push_back(1'b0); eq.push_back(pk(3'd3, 1, kind == 2, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      aq.push_back(1'b1);
      if (kind == 1) begin
        eq.push_back(pk(3'd3, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        aq.push_back(1'($urandom_range(0, 1))); eq.push_back(pk(3'd4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      end else begin
        eq.push_back(pk(3'd3, 1, 1, 1, 0, 0, 1, 0, 0, 0, 1));
      end
    end
    for (int i = 0; i < eq.size(); i++) begin
      mem_ack = aq[i];
      @(negedge clk);
      obs = obs_vec();
      checks++;
      if (obs !== eq[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got st/outs %h expected %h", tag, i, obs, eq[i]);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    model_instret = model_instret + 4'd1;
    checks++;
    if (instret !== model_instret) begin
      errors++; $display("FAIL %s instret: got %0d expected %0d", tag, instret, model_instret);
    end
    checks++;
    if (state !== (hl ? 3'd5 : 3'd0) || fault !== 1'b0) begin
      errors++; $display("FAIL %s end state: got %0d fault %b expected %0d fault 0", tag, state, fault, hl ? 5 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {mem_ack, is_load, is_store, branch, setflags, regwrite, halt} = '1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== 13'd0 || instret !== 4'd0 || fault !== 1'b0) begin
      errors++; $display("FAIL reset: got outs %h instret %0d fault %b expected all 0", obs_vec(), instret, fault);
    end
    do_reset();
  endtask

  task automatic test_alu();
    run_instr("alu", 0, 0, 0, 1, 1, 0, 0, 0);
    checks++;
    if (instret !== 4'd1) begin
      errors++; $display("FAIL alu_instret: got %0d expected 1", instret);
    end
  endtask

  task automatic test_load_delays();
    run_instr("load_delay", 1, 2, 1, 0, 0, 0, 0, 0);
    run_instr("load_and_store", 1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_store_branch();
    run_instr("store_branch", 2, 0, 0, 0, 0, 1, 0, 0);
    run_instr("taken_b", 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL timeout_wait cycle %0d: got %h expected FETCH req", c, obs_vec());
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd6 || fault !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL timeout_fault cycle %0d: got state %0d fault %b req %b expected 6 1 0", c, state, fault, mem_req);
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
    end
    do_reset();
    run_instr("ack_on_5th_fetch", 0, 4, 0, 0, 1, 0, 0, 0);
    run_instr("ack_on_5th_mem", 1, 0, 4, 1, 0, 0, 0, 0);
  endtask

  task automatic test_halt();
    do_reset();
    run_instr("halt_alu", 0, 1, 0, 1, 1, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs_vec() !== pk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0) || instret !== 4'd1) begin
        errors++; $display("FAIL halted cycle %0d: got %h instret %0d expected HALTED idle, 1", c, obs_vec(), instret);
      end
      @(posedge clk); #1;
    end
    do_reset();
    run_instr("halt_store", 2, 0, 2, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_memory();
    do_reset();
    run_instr("pre_alu", 0, 0, 0, 0, 1, 0, 0, 0);
    is_load = 1'b1; is_store = 1'b0; halt = 1'b0;
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || mem_req !== 1'b1) begin
      errors++; $display("FAIL mid_mem_setup: got state %0d req %b expected 3 1", state, mem_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instret !== 4'd0 || state !== 3'd0) begin
      errors++; $display("FAIL async_reset: got req %b instret %0d state %0d expected 0 0 0", mem_req, instret, state);
    end
    model_instret = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    run_instr("restart_load", 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 17; n++) run_instr("wrap_alu", 0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (instret !== 4'd1) begin
      errors++; $display("FAIL wrap: got instret %0d expected 1", instret);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      run_instr("random", int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_delays();
    test_store_branch();
    test_timeout();
    test_halt();
    test_reset_mid_memory();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Control sequencer for the multicycle LEGv8 core, the successor to the single-cycle datapath. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. Talks to a variable-latency, shared instruction/data memory over a req/ack handshake. Adds a retired-instruction counter, a halt state and a sticky memory-timeout fault, none of which the single-cycle core has.

## Interface
- CNTWIDTH, 32, width of the retired-instruction counter
- TIMEOUT, 255, max wait cycles per memory request before fault; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_ack  in  1  memory completed the current request this cycle
- is_load  in  1  decoded LDUR-class instruction (valid DECODE onward, held by IR)
- is_store  in  1  decoded STUR-class instruction
- branch  in  1  branch taken (from branchcontrol, valid in EXECUTE)
- setflags  in  1  instruction sets flags
- regwrite  in  1  non-load instruction writes a register (includes BL link)
- halt  in  1  stop after the current instruction retires
- mem_req  out  1  memory request
- mem_we  out  1  request is a write
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result
- ir_en  out  1  load instruction register
- mdr_en  out  1  load memory data register
- pc_en  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- reg_we  out  1  register file write enable
- flags_we  out  1  flags register write enable
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  CNTWIDTH  retired-instruction count
- state  out  3  current state: FETCH 0, DECODE 1, EXECUTE 2, MEMORY 3, WRITEBACK 4, HALTED 5, FAULT 6
- fault  out  1  sticky timeout indication

## Operation
- All control outputs are combinational decodes of state and inputs. state, instret, fault and the wait counter are registered.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ack: ir_en=1, go to DECODE.
- DECODE: no enables asserted; register read happens here. Go to EXECUTE.
- EXECUTE, when is_load or is_store:
  - Go to MEMORY.
  - No enables asserted; branch is ignored.
- EXECUTE, otherwise:
  - Assert flags_we=setflags, reg_we=regwrite, pc_en=1, pc_src=branch and retire=1.
  - Go to HALTED if halt, else FETCH.
- MEMORY:
  - mem_req=1, addr_sel=1, mem_we=is_store && !is_load.
  - On mem_ack with a load: mdr_en=1, go to WRITEBACK.
  - On mem_ack with a store: pc_en=1, pc_src=0, retire=1, go to HALTED if halt, else FETCH.
- WRITEBACK: reg_we=1, pc_en=1, pc_src=0, retire=1. Go to HALTED if halt, else FETCH.
- is_load and is_store both high: treated as a load.
- mem_ack outside FETCH/MEMORY is ignored.
- HALTED and FAULT:
  - All enables and mem_req are 0.
  - Both states are left only by reset.
- Wait counter:
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle in those states while mem_ack=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ack=0, the next state is FAULT and fault=1.
  - mem_ack arriving in that same cycle wins: no fault.
- instret increments by 1 on every retire cycle and wraps modulo 2^CNTWIDTH.

## Timing
- While rst=0:
  - state=FETCH; instret=0, fault=0, wait counter=0.
  - All outputs are forced to 0, including mem_req.
- First cycle after rst deasserts: FETCH with mem_req=1.
- Reset asserted mid-request drops mem_req immediately (asynchronous). The memory must tolerate abandoned requests.
- A request is accepted on the first cycle mem_ack=1, which can be the cycle mem_req rises.
- Minimum latency with zero-wait memory: ALU or branch 3 cycles, store 4, load 5. Each cycle without ack adds 1.
- retire, pc_en, reg_we and flags_we are single-cycle pulses.
- instret reflects a retirement the cycle after the retire pulse.

## Test plan
- Reset, then ALU instruction (regwrite=1, setflags=1) with ack held at 1: states 0,1,2,0. In cycle 3, reg_we, flags_we, pc_en and retire are all 1. instret=1 afterwards.
- Load with fetch ack delayed 2 cycles and data ack delayed 1 cycle: states 0,0,0,1,2,3,3,4,0. mdr_en pulses on the cycle ack arrives in MEMORY. reg_we pulses in WRITEBACK.
- Store with branch=1: mem_we=1, addr_sel=1 in MEMORY; pc_src=0 at retire. Taken B (no memory) retires with pc_src=1.
- TIMEOUT=4, mem_ack never asserted: FETCH for 5 cycles, then state=6, fault=1, mem_req=0. A later ack has no effect. Repeat with ack on the 5th cycle: no fault.
- halt=1 at retire: state=5, no further mem_req. rst pulse mid-MEMORY: mem_req drops asynchronously, instret=0, restart in FETCH.
- CNTWIDTH=4, 17 back-to-back ALU instructions: instret wraps to 1.
